pll_reset_sequencer: RTL and testbench

//  Parametrised PLL bring-up and reset sequencer, clocked from the PLL reference clock.
//  - Pulses the PLL reset and qualifies its lock output with a stable-lock filter.
//  - Retries on lock timeout.
//  - Releases NUM_CH downstream synchronous resets in staggered order, and re-sequences on loss of lock.
//  - Successor to the single fixed Gowin_rPLL instance: adds supervision and multi-domain reset control.

---
 rtl/pll_reset_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   PLL bring-up and reset sequencer clocked from the PLL reference clock.
//   Pulses the PLL reset, qualifies lock with a stable-lock filter, retries
//   on lock timeout, releases NUM_CH downstream resets in staggered order
//   and re-sequences on loss of lock.
//   Optional feature macro: PLL_SEQ_LOSS_COUNT_EN adds a saturating
//   lock-loss counter output loss_cnt[7:0].
module pll_reset_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              locked,
    output logic              lock_lost,
    output logic              fail,
    output logic [3:0]        retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]        loss_cnt
`endif
);

    localparam int PW = $clog2(RST_PULSE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int RW = $clog2(STAGGER * NUM_CH + 1);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              lock_meta_r;
    logic              lock_sync_r;
    logic [PW-1:0]     pulse_cnt_r;
    logic [PW-1:0]     pulse_cnt_s;
    logic [TW-1:0]     to_cnt_r;
    logic [TW-1:0]     to_cnt_s;
    logic [SW-1:0]     st_cnt_r;
    logic [SW-1:0]     st_cnt_s;
    logic [SW-1:0]     st_inc_s;
    logic [RW-1:0]     rel_cnt_r;
    logic [RW-1:0]     rel_cnt_s;
    logic [RW-1:0]     rel_inc_s;
    logic [3:0]        retry_s;
    logic [NUM_CH-1:0] ch_rst_s;
    logic              lost_s;

    // Two-flop synchroniser bringing the asynchronous PLL lock into clkin
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, counter and channel-reset decisions from the synced lock
    always_comb begin
        state_s     = state_r;
        pulse_cnt_s = pulse_cnt_r;
        to_cnt_s    = to_cnt_r;
        st_cnt_s    = st_cnt_r;
        st_inc_s    = {SW{1'b0}};
        rel_cnt_s   = rel_cnt_r;
        rel_inc_s   = rel_cnt_r + RW'(1);
        retry_s     = retry_cnt;
        ch_rst_s    = {NUM_CH{1'b1}};
        lost_s      = 1'b0;
        case (state_r)
            RST_PLL: begin
                if (pulse_cnt_r >= PW'(RST_PULSE)) begin
                    state_s  = WAIT_LOCK;
                    to_cnt_s = {TW{1'b0}};
                    st_cnt_s = {SW{1'b0}};
                end else begin
                    pulse_cnt_s = pulse_cnt_r + PW'(1);
                end
            end
            WAIT_LOCK, STABLE: begin
                // Timeout wins over any lock-filter progress in the same cycle
                if (to_cnt_r == TW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt == 4'(MAX_RETRY)) begin
                        state_s = FAIL;
                    end else begin
                        retry_s     = retry_cnt + 4'd1;
                        state_s     = RST_PLL;
                        pulse_cnt_s = PW'(1);
                    end
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                    if (lock_sync_r) begin
                        if (state_r == WAIT_LOCK) begin
                            st_inc_s = SW'(1);
                        end else begin
                            st_inc_s = st_cnt_r + SW'(1);
                        end
                        if (st_inc_s >= SW'(LOCK_STABLE)) begin
                            state_s   = RELEASE;
                            st_cnt_s  = {SW{1'b0}};
                            rel_cnt_s = {RW{1'b0}};
                        end else begin
                            state_s  = STABLE;
                            st_cnt_s = st_inc_s;
                        end
                    end else begin
                        state_s  = WAIT_LOCK;
                        st_cnt_s = {SW{1'b0}};
                    end
                end
            end
            RELEASE, RUN: begin
                if (!lock_sync_r) begin
                    // Loss of lock outranks a channel release due this cycle
                    lost_s      = 1'b1;
                    retry_s     = 4'd0;
                    state_s     = RST_PLL;
                    pulse_cnt_s = PW'(1);
                    rel_cnt_s   = {RW{1'b0}};
                end else if (state_r == RELEASE) begin
                    rel_cnt_s = rel_inc_s;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (rel_inc_s == RW'(STAGGER * (i + 1))) begin
                            ch_rst_s[i] = 1'b0;
                        end else begin
                            ch_rst_s[i] = ch_rst[i];
                        end
                    end
                    if (rel_inc_s == RW'(STAGGER * NUM_CH)) begin
                        state_s = RUN;
                    end else begin
                        state_s = RELEASE;
                    end
                end else begin
                    ch_rst_s = ch_rst;
                end
            end
            FAIL: begin
                state_s = FAIL;
            end
            default: begin
                state_s     = RST_PLL;
                pulse_cnt_s = {PW{1'b0}};
                retry_s     = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r     <= RST_PLL;
            pulse_cnt_r <= {PW{1'b0}};
            to_cnt_r    <= {TW{1'b0}};
            st_cnt_r    <= {SW{1'b0}};
            rel_cnt_r   <= {RW{1'b0}};
            retry_cnt   <= 4'd0;
            pll_reset   <= 1'b1;
            ch_rst      <= {NUM_CH{1'b1}};
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_r     <= state_s;
            pulse_cnt_r <= pulse_cnt_s;
            to_cnt_r    <= to_cnt_s;
            st_cnt_r    <= st_cnt_s;
            rel_cnt_r   <= rel_cnt_s;
            retry_cnt   <= retry_s;
            pll_reset   <= (state_s == RST_PLL) || (state_s == FAIL);
            ch_rst      <= ch_rst_s;
            locked      <= (state_r == RUN) && (state_s == RUN);
            lock_lost   <= lost_s;
            fail        <= (state_s == FAIL);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    // Saturating count of lock-loss events since the last reset
    always_ff @(posedge clkin) begin
        if (reset) begin
            loss_cnt <= 8'd0;
        end else if (lost_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end else begin
            loss_cnt <= loss_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios plus randomized
// lock patterns, all checked against a behavioural model of the sequence.
module tb_pll_reset_sequencer;

    localparam int NUM_CH       = 3;
    localparam int RST_PULSE    = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int STAGGER      = 2;
    localparam int MAX_RETRY    = 2;

    logic              clkin    = 1'b0;
    logic              reset    = 1'b1;
    logic              pll_lock = 1'b0;
    logic              pll_reset;
    logic [NUM_CH-1:0] ch_rst;
    logic              locked;
    logic              lock_lost;
    logic              fail;
    logic [3:0]        retry_cnt;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0]        loss_cnt;
`endif

    pll_reset_sequencer #(
        .NUM_CH      (NUM_CH),
        .RST_PULSE   (RST_PULSE),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGGER     (STAGGER),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .ch_rst   (ch_rst),
        .locked   (locked),
        .lock_lost(lock_lost),
        .fail     (fail),
        .retry_cnt(retry_cnt)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .loss_cnt (loss_cnt)
`endif
    );

    always #5 clkin = ~clkin;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = -1;

    // Behavioural model: phase 0 = PLL reset pulse, 1 = acquiring lock,
    // 2 = releasing/running (channel state derived from elapsed time), 3 = failed
    int m_phase = 0;
    int m_pulse = 0;
    int m_wait  = 0;
    int m_run   = 0;
    int m_rel   = 0;
    int m_retry = 0;
    int m_s1    = 0;
    int m_s2    = 0;
    int m_loss  = 0;
    bit m_lost  = 1'b0;

    task automatic model_edge();
        int ls;
        ls     = m_s2;
        m_lost = 1'b0;
        if (reset) begin
            m_phase = 0; m_pulse = 0; m_wait = 0; m_run = 0;
            m_rel = 0; m_retry = 0; m_loss = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_pulse >= RST_PULSE) begin
                        m_phase = 1; m_wait = 0; m_run = 0;
                    end else begin
                        m_pulse++;
                    end
                end
                1: begin
                    if (m_wait + 1 >= LOCK_TIMEOUT) begin
                        if (m_retry == MAX_RETRY) begin
                            m_phase = 3;
                        end else begin
                            m_retry++; m_phase = 0; m_pulse = 1;
                        end
                    end else begin
                        m_wait++;
                        m_run = (ls != 0) ? m_run + 1 : 0;
                        if (m_run >= LOCK_STABLE) begin
                            m_phase = 2; m_rel = 0;
                        end
                    end
                end
                2: begin
                    if (ls == 0) begin
                        m_lost = 1'b1; m_retry = 0; m_phase = 0; m_pulse = 1;
                        if (m_loss < 255) m_loss++;
                    end else begin
                        m_rel++;
                    end
                end
                default: begin
                end
            endcase
        end
        if (reset) begin
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_s2 = m_s1; m_s1 = int'(pll_lock);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_ch_rst();
        logic [NUM_CH-1:0] e;
        e = {NUM_CH{1'b1}};
        if (m_phase == 2) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_rel >= STAGGER * (i + 1)) e[i] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("pll_reset", 32'(pll_reset), 32'((m_phase == 0) || (m_phase == 3)));
        check("ch_rst", 32'(ch_rst), 32'(exp_ch_rst()));
        check("locked", 32'(locked), 32'((m_phase == 2) && (m_rel >= STAGGER * NUM_CH + 1)));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
        check("fail", 32'(fail), 32'(m_phase == 3));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
`ifdef PLL_SEQ_LOSS_COUNT_EN
        check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it
    task automatic tick(input logic rst_v, input logic lock_v);
        reset    = rst_v;
        pll_lock = lock_v;
        @(posedge clkin);
        model_edge();
        cyc = rst_v ? -1 : cyc + 1;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    endtask

    // Hold lock high until locked rises; returns its cycle or -1 on budget expiry
    task automatic run_until_locked(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b1);
            if (locked === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int first_fail;
        int rises;
        int lost_at;
        int pulses;
        int mode;
        int ch_fall [NUM_CH];
        logic prev_rst;

        // Reset state
        do_reset();
        check("reset_ch_rst", 32'(ch_rst), 32'(3'b111));
        check("reset_pll_reset", 32'(pll_reset), 32'(1'b1));

        // Scenario 1: lock present from cycle 0
        for (int i = 0; i < NUM_CH; i++) ch_fall[i] = -1;
        at = -1;
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1);
            if (cyc == 3) check("s1_pll_reset_c3", 32'(pll_reset), 32'(1'b1));
            if (cyc == 4) check("s1_pll_reset_c4", 32'(pll_reset), 32'(1'b0));
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_rst[k] === 1'b0 && ch_fall[k] < 0) ch_fall[k] = cyc;
            end
            if (locked === 1'b1 && at < 0) at = cyc;
        end
        check("s1_ch0_fall", 32'(ch_fall[0]), 32'(14));
        check("s1_ch1_fall", 32'(ch_fall[1]), 32'(16));
        check("s1_ch2_fall", 32'(ch_fall[2]), 32'(18));
        check("s1_locked_at", 32'(at), 32'(19));

        // Scenario 4: one-cycle lock drop in RUN, then re-lock
        tick(1'b0, 1'b0);
        pulses  = 0;
        lost_at = -1;
        at      = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1);
            if (lock_lost === 1'b1) begin
                pulses++;
                if (lost_at < 0) begin
                    lost_at = cyc;
                    check("s4_ch_rst_after_loss", 32'(ch_rst), 32'(3'b111));
                    check("s4_retry_after_loss", 32'(retry_cnt), 32'(0));
                end
            end
            if (locked === 1'b1 && lost_at >= 0 && at < 0) at = cyc;
        end
        check("s4_lost_pulses", 32'(pulses), 32'(1));
        check("s4_relock_delay", 32'(at - lost_at), 32'(19));

        // Scenario 2: lock never arrives
        do_reset();
        first_fail = -1;
        rises      = 0;
        prev_rst   = 1'b1;
        for (int i = 0; i < 215; i++) begin
            tick(1'b0, 1'b0);
            if (pll_reset === 1'b1 && prev_rst === 1'b0) rises++;
            prev_rst = pll_reset;
            if (cyc == 70) check("s2_retry1", 32'(retry_cnt), 32'(1));
            if (cyc == 140) check("s2_retry2", 32'(retry_cnt), 32'(2));
            if (fail === 1'b1 && first_fail < 0) first_fail = cyc;
        end
        check("s2_fail_at", 32'(first_fail), 32'(204));
        check("s2_reset_rises", 32'(rises), 32'(3));
        check("s2_fail_ch_rst", 32'(ch_rst), 32'(3'b111));

        // Scenario 3: 3-cycle glitch during the stable filter
        do_reset();
        rises = 0;
        at    = -1;
        for (int i = 0; i < 35; i++) begin
            tick(1'b0, !((cyc + 1) >= 8 && (cyc + 1) <= 10));
            if (cyc > 3 && pll_reset === 1'b1) rises++;
            if (locked === 1'b1 && at < 0) at = cyc;
        end
        check("s3_locked_at", 32'(at), 32'(27));
        check("s3_no_pll_reset", 32'(rises), 32'(0));

        // Scenario 5: reset during RELEASE after channel 0 released
        do_reset();
        while (cyc < 15) tick(1'b0, 1'b1);
        check("s5_ch0_released", 32'(ch_rst), 32'(3'b110));
        tick(1'b1, 1'b1);
        check("s5_ch_rst_reset", 32'(ch_rst), 32'(3'b111));
        check("s5_pll_reset", 32'(pll_reset), 32'(1'b1));
        run_until_locked(40, at);
        check("s5_relock_at", 32'(at), 32'(19));

        // Randomized lock behaviour with occasional resets
        do_reset();
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) mode = int'($urandom_range(0, 3));
            case (mode)
                0: tick($urandom_range(0, 999) == 0, 1'b1);
                1: tick($urandom_range(0, 699) == 0, $urandom_range(0, 59) != 0);
                2: tick($urandom_range(0, 699) == 0, 1'($urandom_range(0, 1)));
                default: tick($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0);
            endcase
        end

`ifdef PLL_SEQ_LOSS_COUNT_EN
        // Scenario 6: 300 loss events saturate the loss counter
        do_reset();
        for (int n = 0; n < 300; n++) begin
            run_until_locked(60, at);
            if (at < 0) check("s6_lock_budget", 32'(at), 32'(0));
            tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        check("s6_loss_sat", 32'(loss_cnt), 32'(255));
        tick(1'b1, 1'b0);
        check("s6_loss_clear", 32'(loss_cnt), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
